// File: rtl/ball_physics_engine.sv
// Ball physics engine: steps the ball once per movement tick, bounces it off walls and players, and scores hoop entries.
// Optional build macro SPEEDUP_EN: each accepted player hit raises the per-tick step by 1, saturating at 7.
module ball_physics_engine #(
    parameter int BALL_RADIUS        = 8,
    parameter int PLAYER_RADIUS      = 35,
    parameter int GOAL_RADIUS        = 30,
    parameter int GOAL_COUNT         = 3,
    parameter int GOAL_X0            = 300,
    parameter int GOAL_SPACING       = 100,
    parameter int RED_GOAL_Y         = 100,
    parameter int BLUE_GOAL_Y        = 450,
    parameter int X_MIN              = 150,
    parameter int X_MAX              = 660,
    parameter int Y_MIN              = 36,
    parameter int Y_MAX              = 510,
    parameter int CENTER_X           = 463,
    parameter int CENTER_Y           = 275,
    parameter int MOVEMENT_FREQUENCY = 200000,
    parameter int STEP               = 1,
    parameter int SCORE_HOLD         = 64,
    parameter int COLLIDE_COOLDOWN   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_initiated,
    input  logic       game_over,
    input  logic [9:0] team1_hor_pos,
    input  logic [9:0] team1_ver_pos,
    input  logic [9:0] team2_hor_pos,
    input  logic [9:0] team2_ver_pos,
    output logic [9:0] x_position,
    output logic [9:0] y_position,
    output logic       blue_score_up,
    output logic       red_score_up,
    output logic [1:0] ball_state
);

    typedef enum logic [1:0] {
        DEAD   = 2'd0,
        MOVING = 2'd1,
        SCORED = 2'd2,
        SERVE  = 2'd3
    } state_t;

    localparam int CNT_W  = $clog2(MOVEMENT_FREQUENCY);
    localparam int HOLD_W = $clog2(SCORE_HOLD + 1);
    localparam int COOL_W = (COLLIDE_COOLDOWN > 0) ? $clog2(COLLIDE_COOLDOWN + 1) : 1;

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(MOVEMENT_FREQUENCY - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCORE_HOLD - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COLLIDE_COOLDOWN);

    localparam logic [21:0] GOAL_HIT_R2   = 22'((GOAL_RADIUS - BALL_RADIUS) * (GOAL_RADIUS - BALL_RADIUS));
    localparam logic [21:0] PLAYER_HIT_R2 = 22'((PLAYER_RADIUS + BALL_RADIUS) * (PLAYER_RADIUS + BALL_RADIUS));

    localparam logic [9:0] X_LO    = 10'(X_MIN + BALL_RADIUS);
    localparam logic [9:0] X_HI    = 10'(X_MAX - BALL_RADIUS);
    localparam logic [9:0] Y_LO    = 10'(Y_MIN + BALL_RADIUS);
    localparam logic [9:0] Y_HI    = 10'(Y_MAX - BALL_RADIUS);
    localparam logic [9:0] CX      = 10'(CENTER_X);
    localparam logic [9:0] CY      = 10'(CENTER_Y);
    localparam logic [9:0] RED_HY  = 10'(RED_GOAL_Y);
    localparam logic [9:0] BLUE_HY = 10'(BLUE_GOAL_Y);

    state_t state_q, state_d;

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [COOL_W-1:0] cool_q, cool_d;
    logic              dir_x_q, dir_x_d;
    logic              dir_y_q, dir_y_d;
    logic [9:0]        x_d, y_d;
    logic              blue_d, red_d;

    logic [GOAL_COUNT-1:0] red_hoop_hit, blue_hoop_hit;
    logic                  team1_hit, team2_hit;
    logic [9:0]            hit_px, hit_py;
    logic [2:0]            move_step;
    logic signed [11:0]    nx, ny;

`ifdef SPEEDUP_EN
    logic [2:0] step_q, step_d;
`endif

    // Squared Euclidean distance; differences stay within 11 signed bits, so 22 bits never wrap.
    function automatic logic [21:0] dist2(input logic [9:0] ax, input logic [9:0] ay,
                                          input logic [9:0] bx, input logic [9:0] by);
        logic signed [10:0] dx, dy;
        logic [10:0]        mag_x, mag_y;
        dx    = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy    = $signed({1'b0, ay}) - $signed({1'b0, by});
        mag_x = dx[10] ? 11'(-dx) : 11'(dx);
        mag_y = dy[10] ? 11'(-dy) : 11'(dy);
        return 22'(mag_x) * 22'(mag_x) + 22'(mag_y) * 22'(mag_y);
    endfunction

    assign tick       = (tick_cnt == TICK_LAST);
    assign ball_state = state_q;

    for (genvar i = 0; i < GOAL_COUNT; i++) begin : g_hoop
        localparam logic [9:0] HX = 10'(GOAL_X0 + i * GOAL_SPACING);
        assign red_hoop_hit[i]  = dist2(x_position, y_position, HX, RED_HY) < GOAL_HIT_R2;
        assign blue_hoop_hit[i] = dist2(x_position, y_position, HX, BLUE_HY) < GOAL_HIT_R2;
    end

    assign team1_hit = dist2(x_position, y_position, team1_hor_pos, team1_ver_pos) < PLAYER_HIT_R2;
    assign team2_hit = dist2(x_position, y_position, team2_hor_pos, team2_ver_pos) < PLAYER_HIT_R2;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Within a movement tick the goal test wins over collision, and a collision redirects the same tick's move.
    always_comb begin
        state_d = state_q;
        x_d     = x_position;
        y_d     = y_position;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        hold_d  = hold_q;
        cool_d  = cool_q;
        blue_d  = 1'b0;
        red_d   = 1'b0;
        hit_px  = team1_hor_pos;
        hit_py  = team1_ver_pos;
        nx      = '0;
        ny      = '0;
`ifdef SPEEDUP_EN
        step_d    = step_q;
        move_step = step_q;
`else
        move_step = 3'(STEP);
`endif
        if (game_over) begin
            state_d = DEAD;
            x_d     = CX;
            y_d     = CY;
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
`ifdef SPEEDUP_EN
            step_d  = 3'(STEP);
`endif
        end else begin
            unique case (state_q)
                DEAD: begin
                    if (game_initiated) begin
                        state_d = MOVING;
                        dir_x_d = 1'b1;
                        dir_y_d = 1'b1;
                    end
                end
                MOVING: begin
                    if (tick) begin
                        if (cool_q != '0) begin
                            cool_d = cool_q - COOL_W'(1);
                        end
                        if (|red_hoop_hit) begin
                            blue_d  = 1'b1;
                            dir_y_d = 1'b1;
                            state_d = SCORED;
                            x_d     = CX;
                            y_d     = CY;
                            hold_d  = '0;
`ifdef SPEEDUP_EN
                            step_d  = 3'(STEP);
`endif
                        end else if (|blue_hoop_hit) begin
                            red_d   = 1'b1;
                            dir_y_d = 1'b0;
                            state_d = SCORED;
                            x_d     = CX;
                            y_d     = CY;
                            hold_d  = '0;
`ifdef SPEEDUP_EN
                            step_d  = 3'(STEP);
`endif
                        end else begin
                            if (cool_q == '0 && (team1_hit || team2_hit)) begin
                                if (!team1_hit) begin
                                    hit_px = team2_hor_pos;
                                    hit_py = team2_ver_pos;
                                end
                                if (x_position > hit_px) begin
                                    dir_x_d = 1'b1;
                                end else if (x_position < hit_px) begin
                                    dir_x_d = 1'b0;
                                end
                                if (y_position > hit_py) begin
                                    dir_y_d = 1'b1;
                                end else if (y_position < hit_py) begin
                                    dir_y_d = 1'b0;
                                end
                                cool_d = COOL_LOAD;
`ifdef SPEEDUP_EN
                                if (step_q != 3'd7) begin
                                    step_d = step_q + 3'd1;
                                end
                                move_step = step_d;
`endif
                            end
                            nx = dir_x_d ? $signed({2'b00, x_position}) + $signed({9'b0, move_step})
                                         : $signed({2'b00, x_position}) - $signed({9'b0, move_step});
                            ny = dir_y_d ? $signed({2'b00, y_position}) + $signed({9'b0, move_step})
                                         : $signed({2'b00, y_position}) - $signed({9'b0, move_step});
                            if (nx < $signed({2'b00, X_LO})) begin
                                x_d     = X_LO;
                                dir_x_d = ~dir_x_d;
                            end else if (nx > $signed({2'b00, X_HI})) begin
                                x_d     = X_HI;
                                dir_x_d = ~dir_x_d;
                            end else begin
                                x_d = nx[9:0];
                            end
                            if (ny < $signed({2'b00, Y_LO})) begin
                                y_d     = Y_LO;
                                dir_y_d = ~dir_y_d;
                            end else if (ny > $signed({2'b00, Y_HI})) begin
                                y_d     = Y_HI;
                                dir_y_d = ~dir_y_d;
                            end else begin
                                y_d = ny[9:0];
                            end
                        end
                    end
                end
                SCORED: begin
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = SERVE;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                SERVE: begin
                    dir_x_d = 1'b1;
                    cool_d  = '0;
                    state_d = MOVING;
                end
                default: begin
                    state_d = DEAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= DEAD;
            x_position    <= CX;
            y_position    <= CY;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            hold_q        <= '0;
            cool_q        <= '0;
            blue_score_up <= 1'b0;
            red_score_up  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_position    <= x_d;
            y_position    <= y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            hold_q        <= hold_d;
            cool_q        <= cool_d;
            blue_score_up <= blue_d;
            red_score_up  <= red_d;
        end
    end

`ifdef SPEEDUP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 3'(STEP);
        end else begin
            step_q <= step_d;
        end
    end
`endif

endmodule

// File: tb/tb_ball_physics_engine.sv
// Randomized bench for ball_physics_engine: every cycle the DUT is compared with an integer model of the game rules.
module tb_ball_physics_engine;

    localparam int MF        = 4;
    localparam int BALL_R    = 8;
    localparam int PLAYER_R  = 35;
    localparam int GOAL_R    = 30;
    localparam int GOAL_CNT  = 3;
    localparam int GX0       = 300;
    localparam int GPITCH    = 100;
    localparam int RED_Y     = 100;
    localparam int BLUE_Y    = 450;
    localparam int XLO       = 150 + BALL_R;
    localparam int XHI       = 660 - BALL_R;
    localparam int YLO       = 36 + BALL_R;
    localparam int YHI       = 510 - BALL_R;
    localparam int CX        = 463;
    localparam int CY        = 275;
    localparam int BASE_STEP = 1;
    localparam int HOLD      = 64;
    localparam int COOL      = 16;

    logic       clk = 1'b0;
    logic       reset, game_initiated, game_over;
    logic [9:0] team1_hor_pos, team1_ver_pos, team2_hor_pos, team2_ver_pos;
    logic [9:0] x_position, y_position;
    logic       blue_score_up, red_score_up;
    logic [1:0] ball_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference game state: direction as +1/-1, state 0 dead, 1 moving, 2 scored, 3 serve.
    int mx, my, mdx, mdy, mstate, mcnt, mcool, mhold, mstep, mblue, mred;
    int blue_dut = 0, red_dut = 0, blue_ref = 0, red_ref = 0;
    int p1x, p1y, p2x, p2y;

    ball_physics_engine #(.MOVEMENT_FREQUENCY(MF)) dut (
        .clk            (clk),
        .reset          (reset),
        .game_initiated (game_initiated),
        .game_over      (game_over),
        .team1_hor_pos  (team1_hor_pos),
        .team1_ver_pos  (team1_ver_pos),
        .team2_hor_pos  (team2_hor_pos),
        .team2_ver_pos  (team2_ver_pos),
        .x_position     (x_position),
        .y_position     (y_position),
        .blue_score_up  (blue_score_up),
        .red_score_up   (red_score_up),
        .ball_state     (ball_state)
    );

    always #5 clk = ~clk;

    function automatic int dist2(int ax, int ay, int bx, int by);
        return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
    endfunction

    function automatic bit inRow(int x, int y, int hy);
        for (int i = 0; i < GOAL_CNT; i++) begin
            if (dist2(x, y, GX0 + i * GPITCH, hy) < (GOAL_R - BALL_R) * (GOAL_R - BALL_R)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep();
        int tick, cool0, px, py, nx, ny;
        mblue = 0;
        mred  = 0;
        if (reset) begin
            mx = CX; my = CY; mdx = 1; mdy = 1; mstate = 0;
            mcnt = 0; mcool = 0; mhold = 0; mstep = BASE_STEP;
            return;
        end
        tick = (mcnt == MF - 1);
        mcnt = (mcnt + 1) % MF;
        if (game_over) begin
            mstate = 0; mx = CX; my = CY; mdx = 1; mdy = 1; mstep = BASE_STEP;
            return;
        end
        case (mstate)
            0: if (game_initiated) begin mstate = 1; mdx = 1; mdy = 1; end
            1: if (tick) begin
                cool0 = mcool;
                if (mcool > 0) mcool--;
                if (inRow(mx, my, RED_Y)) begin
                    mblue = 1; mdy = 1; mstate = 2; mx = CX; my = CY; mhold = 0; mstep = BASE_STEP;
                end else if (inRow(mx, my, BLUE_Y)) begin
                    mred = 1; mdy = -1; mstate = 2; mx = CX; my = CY; mhold = 0; mstep = BASE_STEP;
                end else begin
                    if (cool0 == 0 && (dist2(mx, my, p1x, p1y) < (PLAYER_R + BALL_R) ** 2 ||
                                       dist2(mx, my, p2x, p2y) < (PLAYER_R + BALL_R) ** 2)) begin
                        if (dist2(mx, my, p1x, p1y) < (PLAYER_R + BALL_R) ** 2) begin
                            px = p1x; py = p1y;
                        end else begin
                            px = p2x; py = p2y;
                        end
                        if (mx != px) mdx = (mx > px) ? 1 : -1;
                        if (my != py) mdy = (my > py) ? 1 : -1;
                        mcool = COOL;
`ifdef SPEEDUP_EN
                        if (mstep < 7) mstep++;
`endif
                    end
                    nx = mx + mdx * mstep;
                    ny = my + mdy * mstep;
                    if (nx < XLO) begin nx = XLO; mdx = -mdx; end
                    else if (nx > XHI) begin nx = XHI; mdx = -mdx; end
                    if (ny < YLO) begin ny = YLO; mdy = -mdy; end
                    else if (ny > YHI) begin ny = YHI; mdy = -mdy; end
                    mx = nx;
                    my = ny;
                end
            end
            2: if (tick) begin
                if (mhold == HOLD - 1) mstate = 3;
                else mhold++;
            end
            default: begin mdx = 1; mcool = 0; mstate = 1; end
        endcase
    endtask

    task automatic applyStimulus(input logic rst, input logic go, input logic gi);
        reset          = rst;
        game_over      = go;
        game_initiated = gi;
        team1_hor_pos  = 10'(p1x);
        team1_ver_pos  = 10'(p1y);
        team2_hor_pos  = 10'(p2x);
        team2_ver_pos  = 10'(p2y);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("x_position", x_position, mx);
        checkOutput("y_position", y_position, my);
        checkOutput("ball_state", ball_state, mstate);
        checkOutput("blue_score_up", blue_score_up, mblue);
        checkOutput("red_score_up", red_score_up, mred);
        blue_dut += blue_score_up;
        red_dut  += red_score_up;
        blue_ref += mblue;
        red_ref  += mred;
    endtask

    function automatic int clampPos(int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    task automatic farPlayers();
        p1x = 0; p1y = 0; p2x = 1000; p2y = 1000;
    endtask

    initial begin
        int  xmax, ymax, sel;
        bit  go_goal_done;
        logic rst_v, go_v, gi_v;

        farPlayers();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("reset_x", x_position, 463);
        checkOutput("reset_y", y_position, 275);
        checkOutput("reset_state", ball_state, 0);

        // Start from DEAD: first move lands three clocks after the start cycle, then every four.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("start_state", ball_state, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pre_tick_x", x_position, 463);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("tick1_x", x_position, 464);
        checkOutput("tick1_y", y_position, 276);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("tick2_x", x_position, 465);
        checkOutput("tick2_y", y_position, 277);

        // Player just below the centre turns the ball upward; cooldown blocks a repeat while overlapping.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("game_over_state", ball_state, 0);
        checkOutput("game_over_x", x_position, 463);
        p1x = 463; p1y = 300;
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8 && x_position == 10'd463; i++) applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef SPEEDUP_EN
        checkOutput("collide_x", x_position, 465);
        checkOutput("collide_y", y_position, 273);
`else
        checkOutput("collide_x", x_position, 464);
        checkOutput("collide_y", y_position, 274);
`endif
        for (int i = 0; i < 20 * MF; i++) applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef SPEEDUP_EN
        checkOutput("post_collide_y", y_position, 233);
`else
        checkOutput("post_collide_y", y_position, 254);
`endif

        // Free flight from the centre reaches the right wall, then the bottom wall.
        farPlayers();
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        xmax = 0;
        ymax = 0;
        for (int i = 0; i < 240 * MF; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (int'(x_position) > xmax) xmax = x_position;
            if (int'(y_position) > ymax) ymax = y_position;
        end
        checkOutput("x_wall_max", xmax, 652);
        checkOutput("y_wall_max", ymax, 502);

        // Random play; the first predicted goal tick is overridden by game_over.
        go_goal_done = 1'b0;
        for (int c = 0; c < 32000; c++) begin
            if (c % 40 == 0) begin
                sel = $urandom_range(0, 3);
                if (sel == 0) begin
                    farPlayers();
                end else if (sel == 3) begin
                    p1x = $urandom_range(150, 660); p1y = $urandom_range(36, 510);
                    p2x = $urandom_range(150, 660); p2y = $urandom_range(36, 510);
                end else begin
                    p1x = clampPos(mx + $urandom_range(0, 90) - 45);
                    p1y = clampPos(my + $urandom_range(0, 90) - 45);
                    p2x = clampPos(mx + $urandom_range(0, 160) - 80);
                    p2y = clampPos(my + $urandom_range(0, 160) - 80);
                end
            end
            rst_v = ($urandom_range(0, 9999) == 0);
            go_v  = ($urandom_range(0, 3999) == 0);
            gi_v  = ($urandom_range(0, 7) == 0);
            if (!go_goal_done && mstate == 1 && mcnt == MF - 1 &&
                (inRow(mx, my, RED_Y) || inRow(mx, my, BLUE_Y))) begin
                go_goal_done = 1'b1;
                applyStimulus(1'b0, 1'b1, 1'b0);
                checkOutput("go_goal_state", ball_state, 0);
                checkOutput("go_goal_blue", blue_score_up, 0);
                checkOutput("go_goal_red", red_score_up, 0);
                checkOutput("go_goal_x", x_position, 463);
                checkOutput("go_goal_y", y_position, 275);
            end else begin
                applyStimulus(rst_v, go_v, gi_v);
            end
        end
        checkOutput("go_goal_reached", go_goal_done, 1);
        checkOutput("blue_goal_count", blue_dut, blue_ref);
        checkOutput("red_goal_count", red_dut, red_ref);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
